// File: rtl/led_counter_pkg.sv
// Shared encodings and defaults for the multi-mode LED counter.
// Latency: none (constants only).
// Backpressure: not applicable.
package led_counter_pkg;

    // Run-time count modes presented on the mode input.
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Direction flag; only bounce mode consumes it, up/down modes refresh it.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One step per second from the 100 MHz board clock.
    localparam int unsigned C_MAX_COUNT_100MHZ = 32'd100_000_000;

    // Binary to reflected Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: divides clk by C_MAX_COUNT, step is high in the last cycle of each period while en=1.
// Latency: step is combinational from the registered prescaler count and en.
// Backpressure: en=0 freezes the count (pause keeps phase); clear restarts the period at 0.
module tick_prescaler #(
    parameter int unsigned C_MAX_COUNT = 32'd100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic step
);

    // A 1-cycle period still needs a one-bit register to stay legal.
    localparam int unsigned PW = (C_MAX_COUNT > 1) ? $clog2(C_MAX_COUNT) : 1;
    localparam logic [PW-1:0] LAST = PW'(C_MAX_COUNT - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Step fires in the final cycle of the period, only while running.
    assign step = en && (presc_q == LAST);

    // Next prescaler value: clear wins, then advance or wrap while enabled, else hold.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (en) begin
            if (presc_q == LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/led_counter_multi.sv
// Multi-mode LED counter (up/down/bounce/hold, wrap or saturate, load); Gray led output when LED_COUNTER_GRAY_OUT_EN is defined.
// Latency: led/tick/wrap are registered and change together one cycle after the updating edge.
// Backpressure: en=0 pauses prescaler and count; load takes effect regardless of en and discards a coincident step.
module led_counter_multi
    import led_counter_pkg::*;
#(
    parameter int          C_WIDTH     = 16,
    parameter int unsigned C_MAX_COUNT = C_MAX_COUNT_100MHZ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               sat,
    input  logic               load,
    input  logic [C_WIDTH-1:0] load_val,
    output logic [C_WIDTH-1:0] led,
    output logic               tick,
    output logic               wrap
);

    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_WIDTH-1:0] CNT_ONE = C_WIDTH'(1);

    logic               step_int;

    logic [C_WIDTH-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [C_WIDTH-1:0] led_q, led_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;

    // Load restarts the period so the next step is a full period after the load.
    tick_prescaler #(
        .C_MAX_COUNT (C_MAX_COUNT)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (load),
        .step  (step_int)
    );

    // Next count/direction/status: load beats step, mode and sat only matter on a step.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (step_int) begin
            tick_d = 1'b1;
            case (mode)
                MODE_UP: begin
                    dir_d = DIR_UP;
                    if (cnt_q == CNT_MAX) begin
                        wrap_d = 1'b1;
                        cnt_d  = sat ? cnt_q : '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (cnt_q == '0) begin
                        wrap_d = 1'b1;
                        cnt_d  = sat ? cnt_q : CNT_MAX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // Turnaround bounces off the end-stop rather than dwelling on it.
                    if (dir_q == DIR_UP) begin
                        if (cnt_q == CNT_MAX) begin
                            cnt_d  = CNT_MAX - 1'b1;
                            dir_d  = DIR_DOWN;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d  = CNT_ONE;
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // Hold: the count stays put but the step is still announced.
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Output encoding is taken from the next count so led never lags cnt.
    always_comb begin
`ifdef LED_COUNTER_GRAY_OUT_EN
        led_d = cnt_d ^ (cnt_d >> 1);
`else
        led_d = cnt_d;
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            led_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_counter_multi.sv
// Bench for led_counter_multi at C_WIDTH=4, C_MAX_COUNT=4: directed scenarios then random stimulus.
// Latency: outputs checked #1 after each rising edge against a behavioural model.
// Backpressure: en/load/rst_n exercised directly.
module tb_led_counter_multi;

    localparam int W    = 4;
    localparam int MAXC = 4;
    localparam int TOP  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic         sat;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] led;
    logic         tick;
    logic         wrap;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: plain integers.
    int  m_cnt   = 0;
    int  m_presc = 0;
    bit  m_down  = 0;
    bit  m_tick  = 0;
    bit  m_wrap  = 0;

    led_counter_multi #(
        .C_WIDTH     (W),
        .C_MAX_COUNT (MAXC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .led      (led),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic int exp_led(input int c);
`ifdef LED_COUNTER_GRAY_OUT_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model reaction to the inputs present at one rising edge.
    task automatic model_edge();
        m_tick = 0;
        m_wrap = 0;
        if (!rst_n) begin
            m_cnt = 0; m_presc = 0; m_down = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_presc = 0;
        end else if (en) begin
            if (m_presc == MAXC - 1) begin
                m_presc = 0;
                m_tick  = 1;
                if (mode == 2'd0) begin
                    m_down = 0;
                    if (m_cnt == TOP) begin m_wrap = 1; m_cnt = sat ? TOP : 0; end
                    else m_cnt = m_cnt + 1;
                end else if (mode == 2'd1) begin
                    m_down = 1;
                    if (m_cnt == 0) begin m_wrap = 1; m_cnt = sat ? 0 : TOP; end
                    else m_cnt = m_cnt - 1;
                end else if (mode == 2'd2) begin
                    if (!m_down && m_cnt == TOP) begin m_cnt = TOP - 1; m_down = 1; m_wrap = 1; end
                    else if (m_down && m_cnt == 0) begin m_cnt = 1; m_down = 0; m_wrap = 1; end
                    else m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    // One clock: edge, model update, then compare all outputs.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("led",  int'(led),  exp_led(m_cnt));
            chk("tick", int'(tick), int'(m_tick));
            chk("wrap", int'(wrap), int'(m_wrap));
        end
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cycle(1);
        load = 1'b0;
    endtask

    int ticks;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; sat = 1'b0; load = 1'b0; load_val = '0;
        #2;

        // Reset: outputs zero even with inputs active.
        en = 1'b1; load = 1'b1; load_val = 4'h5;
        cycle(3);
        chk("reset_led", int'(led), 0);
        chk("reset_tick", int'(tick), 0);
        load = 1'b0;

        // Up count from reset: a step every 4 clocks.
        rst_n = 1'b1; mode = 2'd0;
        cycle(3);
        chk("up_pre_tick", int'(tick), 0);
        cycle(1);
        chk("up_first_step", int'(led), exp_led(1));
        chk("up_first_tick", int'(tick), 1);
        cycle(8);
        chk("up_third_step", int'(led), exp_led(3));

        // Up wrap then saturate.
        do_load(14);
        cycle(4);
        chk("wrap_F", int'(led), exp_led(15));
        cycle(4);
        chk("wrap_0", int'(led), exp_led(0));
        chk("wrap_pulse", int'(wrap), 1);
        sat = 1'b1;
        do_load(15);
        cycle(4);
        chk("sat_hold_F", int'(led), exp_led(15));
        chk("sat_wrap", int'(wrap), 1);
        cycle(4);
        chk("sat_wrap2", int'(wrap), 1);

        // Down with saturation.
        mode = 2'd1;
        do_load(1);
        cycle(4);
        chk("down_0", int'(led), exp_led(0));
        chk("down_nowrap", int'(wrap), 0);
        cycle(4);
        chk("down_sat_0", int'(led), exp_led(0));
        chk("down_sat_wrap", int'(wrap), 1);

        // Bounce from E going up (an up-mode step restores dir=up first).
        mode = 2'd0; sat = 1'b0;
        do_load(0);
        cycle(4);
        mode = 2'd2;
        do_load(14);
        cycle(4);
        chk("bounce_F", int'(led), exp_led(15));
        cycle(4);
        chk("bounce_E", int'(led), exp_led(14));
        chk("bounce_turn_wrap", int'(wrap), 1);
        cycle(4);
        chk("bounce_D", int'(led), exp_led(13));
        do_load(1);
        cycle(8);
        chk("bounce_low_1", int'(led), exp_led(1));
        chk("bounce_low_wrap", int'(wrap), 1);

        // Pause at prescaler=2, then load coincident with a step.
        mode = 2'd0;
        do_load(0);
        cycle(2);
        en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            ticks += int'(tick);
        end
        chk("pause_no_tick", ticks, 0);
        en = 1'b1;
        cycle(1);
        chk("resume_wait", int'(tick), 0);
        cycle(1);
        chk("resume_tick", int'(tick), 1);
        cycle(3);
        do_load(7);
        chk("load_on_step_led", int'(led), exp_led(7));
        chk("load_on_step_tick", int'(tick), 0);
        cycle(3);
        chk("post_load_wait", int'(tick), 0);
        cycle(1);
        chk("post_load_tick", int'(tick), 1);
        chk("post_load_led", int'(led), exp_led(8));

        // Reset mid-period with led=9; dir returns to up.
        mode = 2'd1;
        do_load(9);
        cycle(4);
        do_load(9);
        cycle(2);
        rst_n = 1'b0;
        cycle(1);
        chk("midrst_led", int'(led), 0);
        chk("midrst_tick", int'(tick), 0);
        rst_n = 1'b1; mode = 2'd2;
        cycle(4);
        chk("midrst_dir_up", int'(led), exp_led(1));

        // Gray sequence view of a plain up count 0..3.
        mode = 2'd0;
        do_load(0);
        for (int k = 1; k < 4; k++) begin
            cycle(4);
            chk("seq_led", int'(led), exp_led(k));
        end

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom);
            sat      = 1'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
